arb_multi: RTL and testbench

- N-channel memory request arbiter with ID tagging. It generalises the two-port instruction/data arbiter that sits between the caches/TLB engines and the pipelined line memory.
- Arbitration is per cycle, either fixed-priority or round-robin.
- Read tags come from a bounded pool of live entries. Each response is routed back to its owning channel.
- A per-channel flush drops in-flight reads, for example instruction fetches after a branch misprediction.

---
 rtl/arb_multi.sv | 191 +++++++++++++++++++
 tb/tb_arb_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/arb_multi.sv
// arb_multi: N-channel memory request arbiter with read-tag pool.
// Grants one channel per cycle (fixed priority or round-robin), tags reads
// from a pool of live entries, registers the request toward memory and
// routes tagged responses back to the owning channel. A per-channel flush
// marks that channel's in-flight reads as dropped so their responses
// surface as orphans instead of being delivered.
module arb_multi #(
  parameter int N_CH       = 2,
  parameter int PA_WIDTH   = 32,
  parameter int LINE_BYTES = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUT    = 8,
  parameter int RR_MODE    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CH-1:0]                        i_req_enable,
  input  logic [N_CH-1:0][PA_WIDTH-1:0]          i_req_addr,
  input  logic [N_CH-1:0][LINE_BYTES*8-1:0]      i_req_data,
  input  logic [N_CH-1:0]                        i_req_write,
  input  logic [N_CH-1:0]                        i_flush_ch,
  output logic [N_CH-1:0]                        o_req_grant,
  output logic [ID_WIDTH-1:0]                    o_req_id,
  output logic                                   o_mem_enable,
  output logic                                   o_mem_write,
  output logic [PA_WIDTH-1:0]                    o_mem_addr,
  output logic [LINE_BYTES*8-1:0]                o_mem_data,
  output logic [ID_WIDTH-1:0]                    o_mem_id,
  input  logic                                   i_mem_full,
  input  logic                                   i_resp_enable,
  input  logic [ID_WIDTH-1:0]                    i_resp_id,
  output logic [N_CH-1:0]                        o_resp_valid,
  output logic                                   o_resp_orphan,
  output logic [N_CH-1:0][$clog2(MAX_OUT):0]     o_outstanding
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW   = $clog2(MAX_OUT) + 1;

  // Tag table and arbitration state
  logic [MAX_OUT-1:0]            live_r;
  logic [MAX_OUT-1:0]            dropped_r;
  logic [MAX_OUT-1:0][CH_W-1:0]  owner_r;
  logic [CH_W-1:0]               rr_ptr_r;

  logic                          free_exists_s;
  logic [TW-1:0]                 free_idx_s;
  logic [N_CH-1:0]               elig_s;
  logic                          grant_any_s;
  logic [CH_W-1:0]               grant_idx_s;
  logic                          alloc_s;
  logic                          resp_in_range_s;
  logic [TW-1:0]                 resp_idx_s;
  logic                          resp_live_s;
  logic                          orphan_next_s;

  // Candidate channel examined at search step k (rotated after rr_ptr in RR mode)
  function automatic logic [CH_W-1:0] cand_idx(input logic [CH_W-1:0] ptr, input int k);
    int t;
    if (RR_MODE != 0) t = (int'(ptr) + 32'sd1 + k) % N_CH;
    else              t = k;
    return CH_W'(t);
  endfunction

  // Lowest-index free tag, taken from the registered live bits
  always_comb begin
    free_exists_s = 1'b0;
    free_idx_s    = '0;
    for (int k = MAX_OUT - 1; k >= 0; k--) begin
      if (!live_r[k]) begin
        free_exists_s = 1'b1;
        free_idx_s    = TW'(k);
      end else begin
        free_exists_s = free_exists_s;
      end
    end
  end

  // Eligibility and single-winner grant selection
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      elig_s[c] = i_req_enable[c] && !i_mem_full && !i_flush_ch[c] &&
                  (i_req_write[c] || free_exists_s);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_any_s && elig_s[cand_idx(rr_ptr_r, k)]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_idx(rr_ptr_r, k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    alloc_s     = grant_any_s && !i_req_write[grant_idx_s];
    o_req_grant = '0;
    o_req_id    = '0;
    if (grant_any_s) begin
      o_req_grant[grant_idx_s] = 1'b1;
      o_req_id = free_exists_s ? ID_WIDTH'(free_idx_s) : '0;
    end else begin
      o_req_id = '0;
    end
  end

  // Response lookup: out-of-range ids are never live
  always_comb begin
    resp_in_range_s = ({1'b0, i_resp_id} < (ID_WIDTH+1)'(MAX_OUT));
    resp_idx_s      = resp_in_range_s ? i_resp_id[TW-1:0] : '0;
    resp_live_s     = i_resp_enable && resp_in_range_s && live_r[resp_idx_s];
    orphan_next_s   = i_resp_enable && (!resp_live_s || dropped_r[resp_idx_s]);
    for (int c = 0; c < N_CH; c++) begin
      o_resp_valid[c] = resp_live_s && !dropped_r[resp_idx_s] &&
                        (owner_r[resp_idx_s] == CH_W'(c));
    end
  end

  // Per-channel count of live, non-dropped reads
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      o_outstanding[c] = '0;
      for (int k = 0; k < MAX_OUT; k++) begin
        if (live_r[k] && !dropped_r[k] && (owner_r[k] == CH_W'(c))) begin
          o_outstanding[c] = o_outstanding[c] + CW'(1);
        end else begin
          o_outstanding[c] = o_outstanding[c];
        end
      end
    end
  end

  // Tag table update: allocate, free on response, mark dropped on flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_r    <= '0;
      dropped_r <= '0;
      owner_r   <= '0;
    end else begin
      for (int k = 0; k < MAX_OUT; k++) begin
        if (alloc_s && (free_idx_s == TW'(k))) begin
          live_r[k]    <= 1'b1;
          owner_r[k]   <= grant_idx_s;
          dropped_r[k] <= 1'b0;
        end else if (resp_live_s && (resp_idx_s == TW'(k))) begin
          live_r[k]    <= 1'b0;
        end else if (live_r[k] && i_flush_ch[owner_r[k]]) begin
          dropped_r[k] <= 1'b1;
        end
      end
    end
  end

  // Round-robin pointer follows the last granted channel
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r <= CH_W'(N_CH - 1);
    end else if (grant_any_s) begin
      rr_ptr_r <= grant_idx_s;
    end
  end

  // Registered memory request port; payload holds when nothing is granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_mem_enable <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_mem_id     <= '0;
    end else if (grant_any_s) begin
      o_mem_enable <= 1'b1;
      o_mem_write  <= i_req_write[grant_idx_s];
      o_mem_addr   <= i_req_addr[grant_idx_s];
      o_mem_data   <= i_req_data[grant_idx_s];
      o_mem_id     <= o_req_id;
    end else begin
      o_mem_enable <= 1'b0;
    end
  end

  // Orphan pulse for responses whose tag is dead or dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_resp_orphan <= 1'b0;
    end else begin
      o_resp_orphan <= orphan_next_s;
    end
  end

endmodule

// File: tb/tb_arb_multi.sv
// Testbench for arb_multi: a table-driven round-robin instance (3 channels,
// 4 tags) plus a hand-written fixed-priority sequence (2 channels, 2 tags).
module tb_arb_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- round-robin instance ----------------
  logic                 r_rst;
  logic [2:0]           r_en, r_wr, r_fl, r_grant, r_rv;
  logic [2:0][31:0]     r_addr, r_data;
  logic [3:0]           r_id, r_mid, r_resp_id;
  logic                 r_men, r_mwr, r_full, r_resp_en, r_orph;
  logic [31:0]          r_maddr, r_mdata;
  logic [2:0][2:0]      r_out;

  arb_multi #(.N_CH(3), .PA_WIDTH(32), .LINE_BYTES(4), .ID_WIDTH(4),
              .MAX_OUT(4), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(r_rst),
    .i_req_enable(r_en), .i_req_addr(r_addr), .i_req_data(r_data),
    .i_req_write(r_wr), .i_flush_ch(r_fl),
    .o_req_grant(r_grant), .o_req_id(r_id),
    .o_mem_enable(r_men), .o_mem_write(r_mwr), .o_mem_addr(r_maddr),
    .o_mem_data(r_mdata), .o_mem_id(r_mid), .i_mem_full(r_full),
    .i_resp_enable(r_resp_en), .i_resp_id(r_resp_id),
    .o_resp_valid(r_rv), .o_resp_orphan(r_orph), .o_outstanding(r_out));

  // ---------------- fixed-priority instance ----------------
  logic                 f_rst;
  logic [1:0]           f_en, f_wr, f_fl, f_grant, f_rv;
  logic [1:0][31:0]     f_addr, f_data;
  logic [3:0]           f_id, f_mid, f_resp_id;
  logic                 f_men, f_mwr, f_full, f_resp_en, f_orph;
  logic [31:0]          f_maddr, f_mdata;
  logic [1:0][1:0]      f_out;

  arb_multi #(.N_CH(2), .PA_WIDTH(32), .LINE_BYTES(4), .ID_WIDTH(4),
              .MAX_OUT(2), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(f_rst),
    .i_req_enable(f_en), .i_req_addr(f_addr), .i_req_data(f_data),
    .i_req_write(f_wr), .i_flush_ch(f_fl),
    .o_req_grant(f_grant), .o_req_id(f_id),
    .o_mem_enable(f_men), .o_mem_write(f_mwr), .o_mem_addr(f_maddr),
    .o_mem_data(f_mdata), .o_mem_id(f_mid), .i_mem_full(f_full),
    .i_resp_enable(f_resp_en), .i_resp_id(f_resp_id),
    .o_resp_valid(f_rv), .o_resp_orphan(f_orph), .o_outstanding(f_out));

  typedef struct {
    logic        rst_n;
    logic [2:0]  en, wr, fl;
    logic        full, resp_en;
    logic [3:0]  resp_id;
    logic [2:0]  e_grant;
    logic [3:0]  e_id;
    logic [2:0]  e_rv;
    logic        e_men, e_mwr;
    logic [3:0]  e_mid;
    logic [31:0] e_maddr;
    logic        e_orph;
    logic [2:0]  e_o0, e_o1, e_o2;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic rst_n, input logic [2:0] en, input logic [2:0] wr, input logic [2:0] fl,
      input logic full, input logic resp_en, input logic [3:0] resp_id,
      input logic [2:0] e_grant, input logic [3:0] e_id, input logic [2:0] e_rv,
      input logic e_men, input logic e_mwr, input logic [3:0] e_mid, input logic [31:0] e_maddr,
      input logic e_orph, input logic [2:0] e_o0, input logic [2:0] e_o1, input logic [2:0] e_o2);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.wr = wr; v.fl = fl; v.full = full;
    v.resp_en = resp_en; v.resp_id = resp_id; v.e_grant = e_grant; v.e_id = e_id;
    v.e_rv = e_rv; v.e_men = e_men; v.e_mwr = e_mwr; v.e_mid = e_mid;
    v.e_maddr = e_maddr; v.e_orph = e_orph; v.e_o0 = e_o0; v.e_o1 = e_o1; v.e_o2 = e_o2;
    return v;
  endfunction

  task automatic f_step(input string tag, input logic [1:0] en, input logic [1:0] wr,
                        input logic resp_en, input logic [3:0] resp_id,
                        input logic [1:0] e_grant, input logic [3:0] e_id, input logic [1:0] e_rv,
                        input logic e_men, input logic e_mwr, input logic [1:0] e_o0,
                        input logic [1:0] e_o1);
    @(negedge clk);
    f_en = en; f_wr = wr; f_resp_en = resp_en; f_resp_id = resp_id;
    #1;
    chk({tag, " fp_grant"}, 64'(f_grant), 64'(e_grant));
    chk({tag, " fp_id"},    64'(f_id),    64'(e_id));
    chk({tag, " fp_rv"},    64'(f_rv),    64'(e_rv));
    @(posedge clk); #1;
    chk({tag, " fp_men"},   64'(f_men),   64'(e_men));
    if (e_men) chk({tag, " fp_mwr"}, 64'(f_mwr), 64'(e_mwr));
    chk({tag, " fp_out0"},  64'(f_out[0]), 64'(e_o0));
    chk({tag, " fp_out1"},  64'(f_out[1]), 64'(e_o1));
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      r_addr[c] = 32'h1000 * (c + 1);
      r_data[c] = r_addr[c] + 32'd5;
    end
    for (int c = 0; c < 2; c++) begin
      f_addr[c] = 32'h8000 + 32'h100 * c;
      f_data[c] = 32'h0;
    end
    r_rst = 1'b0; r_en = '0; r_wr = '0; r_fl = '0; r_full = 1'b0;
    r_resp_en = 1'b0; r_resp_id = '0;
    f_rst = 1'b0; f_en = '0; f_wr = '0; f_fl = '0; f_full = 1'b0;
    f_resp_en = 1'b0; f_resp_id = '0;

    //            rst en    wr    fl    full re id     grant  id  rv    men mwr mid  maddr      orph o0 o1 o2
    tbl[0]  = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b001,4'd0,3'b000, 1, 0, 4'd0, 32'h1000, 0, 1,0,0);
    tbl[1]  = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b010,4'd1,3'b000, 1, 0, 4'd1, 32'h2000, 0, 1,1,0);
    tbl[2]  = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b100,4'd2,3'b000, 1, 0, 4'd2, 32'h3000, 0, 1,1,1);
    tbl[3]  = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b001,4'd3,3'b000, 1, 0, 4'd3, 32'h1000, 0, 2,1,1);
    tbl[4]  = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b000,4'd0,3'b000, 0, 0, 4'd3, 32'h1000, 0, 2,1,1);
    tbl[5]  = mk(1, 3'b010,3'b010,3'b000,0, 0, 4'd0, 3'b010,4'd0,3'b000, 1, 1, 4'd0, 32'h2000, 0, 2,1,1);
    tbl[6]  = mk(1, 3'b000,3'b000,3'b000,0, 1, 4'd1, 3'b000,4'd0,3'b010, 0, 1, 4'd0, 32'h2000, 0, 2,0,1);
    tbl[7]  = mk(1, 3'b100,3'b000,3'b000,0, 1, 4'd0, 3'b100,4'd1,3'b001, 1, 0, 4'd1, 32'h3000, 0, 1,0,2);
    tbl[8]  = mk(1, 3'b100,3'b000,3'b100,0, 1, 4'd2, 3'b000,4'd0,3'b100, 0, 0, 4'd1, 32'h3000, 0, 1,0,0);
    tbl[9]  = mk(1, 3'b000,3'b000,3'b000,0, 1, 4'd1, 3'b000,4'd0,3'b000, 0, 0, 4'd1, 32'h3000, 1, 1,0,0);
    tbl[10] = mk(1, 3'b011,3'b000,3'b000,0, 1, 4'd5, 3'b001,4'd0,3'b000, 1, 0, 4'd0, 32'h1000, 1, 2,0,0);
    tbl[11] = mk(1, 3'b111,3'b000,3'b000,1, 0, 4'd0, 3'b000,4'd0,3'b000, 0, 0, 4'd0, 32'h1000, 0, 2,0,0);
    tbl[12] = mk(1, 3'b111,3'b000,3'b000,1, 0, 4'd0, 3'b000,4'd0,3'b000, 0, 0, 4'd0, 32'h1000, 0, 2,0,0);
    tbl[13] = mk(1, 3'b111,3'b000,3'b000,1, 0, 4'd0, 3'b000,4'd0,3'b000, 0, 0, 4'd0, 32'h1000, 0, 2,0,0);
    tbl[14] = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b010,4'd1,3'b000, 1, 0, 4'd1, 32'h2000, 0, 2,1,0);
    tbl[15] = mk(0, 3'b000,3'b000,3'b000,0, 0, 4'd0, 3'b000,4'd0,3'b000, 0, 0, 4'd0, 32'h0000, 0, 0,0,0);
    tbl[16] = mk(1, 3'b000,3'b000,3'b000,0, 1, 4'd1, 3'b000,4'd0,3'b000, 0, 0, 4'd0, 32'h0000, 1, 0,0,0);
    tbl[17] = mk(1, 3'b111,3'b000,3'b000,0, 0, 4'd0, 3'b001,4'd0,3'b000, 1, 0, 4'd0, 32'h1000, 0, 1,0,0);

    // Reset both instances and check the reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst rr_men",  64'(r_men),  64'd0);
    chk("rst rr_orph", 64'(r_orph), 64'd0);
    chk("rst rr_out",  64'(r_out),  64'd0);
    chk("rst rr_maddr",64'(r_maddr),64'd0);
    chk("rst fp_men",  64'(f_men),  64'd0);
    chk("rst fp_out",  64'(f_out),  64'd0);
    @(negedge clk);
    r_rst = 1'b1; f_rst = 1'b1;

    // Round-robin table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      r_rst = tbl[i].rst_n; r_en = tbl[i].en; r_wr = tbl[i].wr; r_fl = tbl[i].fl;
      r_full = tbl[i].full; r_resp_en = tbl[i].resp_en; r_resp_id = tbl[i].resp_id;
      #1;
      chk($sformatf("v%0d grant", i), 64'(r_grant), 64'(tbl[i].e_grant));
      chk($sformatf("v%0d id", i),    64'(r_id),    64'(tbl[i].e_id));
      chk($sformatf("v%0d rv", i),    64'(r_rv),    64'(tbl[i].e_rv));
      @(posedge clk); #1;
      chk($sformatf("v%0d men", i),   64'(r_men),   64'(tbl[i].e_men));
      chk($sformatf("v%0d mwr", i),   64'(r_mwr),   64'(tbl[i].e_mwr));
      chk($sformatf("v%0d mid", i),   64'(r_mid),   64'(tbl[i].e_mid));
      chk($sformatf("v%0d maddr", i), 64'(r_maddr), 64'(tbl[i].e_maddr));
      chk($sformatf("v%0d mdata", i), 64'(r_mdata),
          64'((tbl[i].e_maddr == 32'd0) ? 32'd0 : tbl[i].e_maddr + 32'd5));
      chk($sformatf("v%0d orph", i),  64'(r_orph),  64'(tbl[i].e_orph));
      chk($sformatf("v%0d out0", i),  64'(r_out[0]), 64'(tbl[i].e_o0));
      chk($sformatf("v%0d out1", i),  64'(r_out[1]), 64'(tbl[i].e_o1));
      chk($sformatf("v%0d out2", i),  64'(r_out[2]), 64'(tbl[i].e_o2));
    end
    @(negedge clk);
    r_en = '0; r_resp_en = 1'b0;

    // Fixed priority: ch0 always wins, ch1 only when ch0 drops its request
    //      tag     en     wr    re id   grant  id   rv    men mwr o0 o1
    f_step("p0", 2'b11, 2'b11, 0, 4'd0, 2'b01, 4'd0, 2'b00, 1, 1, 0, 0);
    f_step("p1", 2'b11, 2'b11, 0, 4'd0, 2'b01, 4'd0, 2'b00, 1, 1, 0, 0);
    f_step("p2", 2'b11, 2'b11, 0, 4'd0, 2'b01, 4'd0, 2'b00, 1, 1, 0, 0);
    f_step("p3", 2'b10, 2'b10, 0, 4'd0, 2'b10, 4'd0, 2'b00, 1, 1, 0, 0);
    // Pool of two: reads take tags 0 and 1, third read stalls, write passes
    f_step("p4", 2'b11, 2'b00, 0, 4'd0, 2'b01, 4'd0, 2'b00, 1, 0, 1, 0);
    f_step("p5", 2'b11, 2'b00, 0, 4'd0, 2'b01, 4'd1, 2'b00, 1, 0, 2, 0);
    f_step("p6", 2'b11, 2'b00, 0, 4'd0, 2'b00, 4'd0, 2'b00, 0, 0, 2, 0);
    f_step("p7", 2'b10, 2'b10, 0, 4'd0, 2'b10, 4'd0, 2'b00, 1, 1, 2, 0);
    // Freed tag is allocatable only on the following cycle
    f_step("p8", 2'b10, 2'b00, 1, 4'd0, 2'b00, 4'd0, 2'b01, 0, 0, 1, 0);
    f_step("p9", 2'b10, 2'b00, 0, 4'd0, 2'b10, 4'd0, 2'b00, 1, 0, 1, 1);
    chk("p9 fp_mid", 64'(f_mid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
